updown_seq_ctrl: RTL and testbench
==================================

UPDOWN_SEQ_CTRL -- requirements
Module: updown_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have parameter DIVW, default 8, step-interval field width in bits.
REQ-003 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  in  1  move command offered.
REQ-006 SHALL have port cmd_ready  out  1  controller can accept a command.
REQ-007 SHALL have port cmd_target  in  WIDTH  destination count value, unsigned.
REQ-008 SHALL have port cmd_div  in  DIVW  extra idle cycles between steps.
REQ-009 SHALL have port abort  in  1  cancel the active command.
REQ-010 SHALL have port cnt_q  in  WIDTH  current value of the controlled up/down counter.
REQ-011 SHALL have port cnt_en  out  1  one-cycle step request to the counter.
REQ-012 SHALL have port cnt_up  out  1  counter direction, 1 = up, 0 = down.
REQ-013 SHALL have port busy  out  1  command in progress.
REQ-014 SHALL have port done  out  1  one-cycle pulse, target reached.
REQ-015 SHALL have port aborted  out  1  one-cycle pulse, command cancelled by abort.
REQ-016 SHALL have port error  out  1  one-cycle pulse, step limit exceeded.

Function
REQ-017 SHALL implement states IDLE, RUN, WAIT, DONE; cmd_ready=1 only in IDLE; busy=1 in RUN and WAIT.
REQ-018 SHALL accept a command on a rising edge with cmd_valid&&cmd_ready, latching cmd_target and cmd_div, loading prescaler to 0 and step count to 0.
REQ-019 SHALL on acceptance latch cnt_up = (cmd_target > cnt_q), unsigned compare, and hold it constant until the command ends.
REQ-020 SHALL go IDLE->DONE on acceptance when cmd_target == cnt_q, issuing zero steps; otherwise IDLE->RUN.
REQ-021 SHALL in RUN go to DONE, without asserting cnt_en, when cnt_q == latched target; this check has priority over stepping.
REQ-022 SHALL in RUN with prescaler==0 and target not reached assert cnt_en for exactly that cycle, reload prescaler with latched div, increment step count, go to WAIT.
REQ-023 SHALL in RUN with prescaler!=0 decrement the prescaler and stay in RUN.
REQ-024 SHALL spend exactly one cycle in WAIT, then return to RUN, giving cnt_en a period of div+2 cycles.
REQ-025 SHALL in DONE assert done for one cycle, then go IDLE.
REQ-026 SHALL, when abort=1 in RUN or WAIT, force cnt_en=0 that cycle, pulse aborted next cycle, and return to IDLE; abort in IDLE or DONE is ignored.
REQ-027 SHALL, when a step would make step count exceed 2^WIDTH-1, suppress cnt_en, pulse error next cycle, and return to IDLE.
REQ-028 SHALL ignore cmd_valid while not in IDLE; a command held through busy is accepted on the first IDLE cycle.
REQ-029 SHALL give abort priority over target-reached, and target-reached priority over error, in the same cycle.
REQ-030 SHALL never assert cnt_en outside RUN and never for two consecutive cycles.
REQ-031 SHALL keep done, aborted and error mutually exclusive.

Reset
REQ-032 SHALL on rst enter IDLE immediately: cmd_ready=1, cnt_en=0, cnt_up=0, busy=0, done=0, aborted=0, error=0, prescaler and step count 0.
REQ-033 SHALL discard an in-flight command on rst mid-operation, with no done/aborted/error pulse.

Verification
REQ-034 SHALL pass: cnt_q=3, target 7, div 0 -> cnt_up=1, 4 cnt_en pulses spaced 2 cycles, done 1 cycle after cnt_q=7 seen in RUN.
REQ-035 SHALL pass: cnt_q=9, target 2, div 2 -> cnt_up=0, 7 cnt_en pulses spaced 4 cycles, then done.
REQ-036 SHALL pass: cnt_q=5, target 5 -> zero cnt_en, done on 2nd cycle after accept, busy never 1.
REQ-037 SHALL pass: abort after 2nd step of 0->15 move -> no further cnt_en, aborted pulse, cnt_q=2, cmd_ready=1.
REQ-038 SHALL pass: counter model ignores cnt_en, target 15 from 0 -> 15 cnt_en pulses, then error pulse, IDLE.
REQ-039 SHALL pass: rst asserted in WAIT -> all outputs at REQ-032 values same cycle, no status pulse, next command accepted normally.

Source files
------------

// File: rtl/updown_seq_ctrl.sv
// Step sequencer for an external up/down counter: moves the counter to a commanded
// target one step at a time, with a programmable idle interval between steps.
module updown_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIVW  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic [DIVW-1:0]  cmd_div,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             error
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [WIDTH-1:0] target_q;
    logic [DIVW-1:0]  div_q;
    logic [DIVW-1:0]  presc;
    logic [WIDTH-1:0] step_cnt;

    logic at_target;
    logic step_full;

    assign at_target = (cnt_q == target_q);
    assign step_full = (step_cnt == '1);

    // The step request is combinational so that abort and target-reached can veto it
    // in the same cycle; priority is abort, then target, then the step-count limit.
    assign cnt_en    = (state == S_RUN) && !abort && !at_target
                       && (presc == '0) && !step_full;
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN) || (state == S_WAIT);
    assign done      = (state == S_DONE);

    // NOTE: all state below uses non-blocking assignments so every branch sees the
    // values from before the clock edge, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            target_q <= '0;
            div_q    <= '0;
            presc    <= '0;
            step_cnt <= '0;
            cnt_up   <= 1'b0;
            aborted  <= 1'b0;
            error    <= 1'b0;
        end else begin
            aborted <= 1'b0;
            error   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        target_q <= cmd_target;
                        div_q    <= cmd_div;
                        presc    <= '0;
                        step_cnt <= '0;
                        cnt_up   <= (cmd_target > cnt_q);
                        state    <= (cmd_target == cnt_q) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        aborted <= 1'b1;
                    end else if (at_target) begin
                        state <= S_DONE;
                    end else if (presc == '0) begin
                        if (step_full) begin
                            state <= S_IDLE;
                            error <= 1'b1;
                        end else begin
                            presc    <= div_q;
                            step_cnt <= step_cnt + 1'b1;
                            state    <= S_WAIT;
                        end
                    end else begin
                        presc <= presc - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state   <= S_IDLE;
                        aborted <= 1'b1;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Directed bench for updown_seq_ctrl with a behavioural up/down counter in the loop.
module tb_updown_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int DIVW  = 8;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_target;
    logic [DIVW-1:0]  cmd_div;
    logic             abort;
    logic [WIDTH-1:0] cnt_q;
    logic             cnt_en;
    logic             cnt_up;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             error;

    logic             model_on;
    logic             load;
    logic [WIDTH-1:0] load_val;

    int checks   = 0;
    int failures = 0;

    updown_seq_ctrl #(.WIDTH(WIDTH), .DIVW(DIVW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_div    (cmd_div),
        .abort      (abort),
        .cnt_q      (cnt_q),
        .cnt_en     (cnt_en),
        .cnt_up     (cnt_up),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .error      (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Controlled counter; model_on=0 emulates a counter that ignores step requests.
    always @(posedge clk) begin
        if (load)
            cnt_q <= load_val;
        else if (model_on && cnt_en)
            cnt_q <= cnt_up ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_count(input logic [WIDTH-1:0] v);
        load     = 1'b1;
        load_val = v;
        tick();
        load     = 1'b0;
    endtask

    task automatic issue(input logic [WIDTH-1:0] t, input logic [DIVW-1:0] d);
        cmd_valid  = 1'b1;
        cmd_target = t;
        cmd_div    = d;
        tick();
        cmd_valid  = 1'b0;
    endtask

    // Observe until a status pulse, counting steps; bad counts wrong gaps,
    // back-to-back steps and steps seen while not busy. status = {done,aborted,error}.
    task automatic watch(input int max_cyc, input int gap,
                         output int pulses, output int bad, output logic [2:0] status);
        int  last;
        bit  prev;
        bit  fin;
        last   = -1;
        prev   = 1'b0;
        fin    = 1'b0;
        pulses = 0;
        bad    = 0;
        status = 3'b000;
        for (int i = 0; i < max_cyc && !fin; i++) begin
            if (cnt_en) begin
                if (last >= 0 && i - last != gap) bad++;
                if (prev || !busy) bad++;
                pulses++;
                last = i;
            end
            prev = cnt_en;
            if (done || aborted || error) begin
                status = {done, aborted, error};
                fin    = 1'b1;
            end else begin
                tick();
            end
        end
    endtask

    int         pulses;
    int         bad;
    logic [2:0] status;
    int         stray;

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = '0;
        cmd_div    = '0;
        abort      = 1'b0;
        model_on   = 1'b1;
        load       = 1'b1;
        load_val   = '0;
        tick();
        tick();
        load = 1'b0;

        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_outputs", {cnt_en, cnt_up, busy, done, aborted, error}, 6'b0);
        rst = 1'b0;
        tick();

        // Up move 3 -> 7, div 0
        set_count(4'd3);
        issue(4'd7, 8'd0);
        check("up_dir_busy", {cnt_up, busy, cmd_ready}, 3'b110);
        watch(60, 2, pulses, bad, status);
        check("up_pulses", pulses, 4);
        check("up_spacing", bad, 0);
        check("up_status", status, 3'b100);
        check("up_cnt_q", cnt_q, 7);
        tick();
        check("up_done_end", {done, cmd_ready}, 2'b01);

        // Down move 9 -> 2, div 2
        set_count(4'd9);
        issue(4'd2, 8'd2);
        check("down_dir", cnt_up, 0);
        watch(100, 4, pulses, bad, status);
        check("down_pulses", pulses, 7);
        check("down_spacing", bad, 0);
        check("down_status", status, 3'b100);
        check("down_cnt_q", cnt_q, 2);

        // Already at target: done on the second cycle, never busy
        tick();
        set_count(4'd5);
        issue(4'd5, 8'd3);
        check("same_done", {done, busy, cnt_en}, 3'b100);
        tick();
        check("same_idle", {done, busy, cmd_ready}, 3'b001);

        // Abort in the RUN cycle that would issue the third step of 0 -> 15
        set_count(4'd0);
        issue(4'd15, 8'd0);
        check("ab_step1", cnt_en, 1);
        tick();
        tick();
        check("ab_step2", cnt_en, 1);
        tick();
        check("ab_wait", {cnt_en, busy}, 2'b01);
        tick();
        abort = 1'b1;
        #1;
        check("ab_en_forced_low", {cnt_en, busy}, 2'b01);
        tick();
        abort = 1'b0;
        check("ab_pulse", {aborted, done, error, cmd_ready, busy}, 5'b10010);
        check("ab_cnt_q", cnt_q, 2);
        tick();
        check("ab_pulse_end", aborted, 0);

        // Stuck counter: 15 steps, then the step limit trips
        model_on = 1'b0;
        set_count(4'd0);
        issue(4'd15, 8'd0);
        watch(100, 2, pulses, bad, status);
        check("lim_pulses", pulses, 15);
        check("lim_spacing", bad, 0);
        check("lim_status", status, 3'b001);
        check("lim_idle", {cmd_ready, busy, cnt_en}, 3'b100);
        tick();
        check("lim_err_end", error, 0);
        model_on = 1'b1;

        // Reset while in WAIT
        set_count(4'd0);
        issue(4'd4, 8'd1);
        check("rw_step", {cnt_en, cnt_up}, 2'b11);
        tick();
        check("rw_in_wait", {busy, cnt_en}, 2'b10);
        rst = 1'b1;
        #1;
        check("rw_reset_outputs", {cmd_ready, cnt_en, cnt_up, busy, done, aborted, error},
              7'b1000000);
        tick();
        rst = 1'b0;
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || aborted || error || busy) stray++;
            tick();
        end
        check("rw_no_status", stray, 0);
        check("rw_cnt_q", cnt_q, 1);
        issue(4'd3, 8'd0);
        watch(40, 2, pulses, bad, status);
        check("rw_next_pulses", pulses, 2);
        check("rw_next_status", status, 3'b100);
        check("rw_next_cnt_q", cnt_q, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
